// File: rtl/ai_fpga_pkg.sv
// Shared definitions for the feature-map datapath: element width and the
// state encoding used by the map writer.
package ai_fpga_pkg;

  // Bits per feature-map element (signed two's complement)
  localparam int DATA_WIDTH = 32;

  // Map writer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/map_writer.sv
// map_writer: captures a flattened signed feature map on a start pulse and
// serialises it, one element per accepted beat in row-major order, onto a
// single-port memory write interface. A one-cycle done pulse follows the
// last accepted beat so the next layer can read the stored map back.
module map_writer #(
  parameter int map_width  = 3,
  parameter int DATA_WIDTH = ai_fpga_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [map_width*map_width*DATA_WIDTH-1:0] in_map,
  output logic                                      wr_en,
  output logic [ADDR_WIDTH-1:0]                     wr_addr,
  output logic [DATA_WIDTH-1:0]                     wr_data,
  input  logic                                      wr_ready,
  output logic                                      busy,
  output logic                                      done
);

  import ai_fpga_pkg::*;

  localparam int N       = map_width * map_width;
  localparam int MAP_W   = N * DATA_WIDTH;
  localparam int IDX_W   = $clog2(N + 1);
  localparam int SEL_W   = $clog2(MAP_W) + 1;

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = IDX_W'(0);

  // State and registered outputs
  writer_state_t            state_r;
  writer_state_t            next_state_s;
  logic [IDX_W-1:0]         idx_r;
  logic [MAP_W-1:0]         shadow_r;
  logic                     wr_en_r;
  logic [ADDR_WIDTH-1:0]    wr_addr_r;
  logic [DATA_WIDTH-1:0]    wr_data_r;
  logic                     busy_r;
  logic                     done_r;

  // Next values computed by the output logic
  logic [IDX_W-1:0]         idx_nxt_s;
  logic                     wr_en_nxt_s;
  logic [ADDR_WIDTH-1:0]    addr_nxt_s;
  logic [DATA_WIDTH-1:0]    data_nxt_s;
  logic                     busy_nxt_s;
  logic                     done_nxt_s;
  logic                     load_shadow_s;

  // Beat bookkeeping
  logic                     beat_s;
  logic                     last_s;
  logic [IDX_W-1:0]         idx_inc_s;
  logic [IDX_W-1:0]         elem_idx_s;
  logic [SEL_W-1:0]         sel_s;

  // A beat is accepted only while a request is actually presented
  assign beat_s    = wr_en_r & wr_ready;
  assign last_s    = (idx_r == IDX_LAST);
  assign idx_inc_s = idx_r + IDX_ONE;

  // Bit offset of the element that goes out after this beat; clamped on the
  // final beat so the part-select never points past the end of the shadow map
  always_comb begin
    if (last_s) begin
      elem_idx_s = IDX_ZERO;
    end else begin
      elem_idx_s = idx_inc_s;
    end
    sel_s = SEL_W'(elem_idx_s) * SEL_W'(DATA_WIDTH);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE: begin
        if (beat_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WRITE;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM output logic: next values for the registered outputs and index
  always_comb begin
    idx_nxt_s     = idx_r;
    wr_en_nxt_s   = wr_en_r;
    addr_nxt_s    = wr_addr_r;
    data_nxt_s    = wr_data_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    load_shadow_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          // Element 0 comes straight from the bus; the shadow copy is
          // loaded in the same cycle and serves every later element.
          load_shadow_s = 1'b1;
          idx_nxt_s     = IDX_ZERO;
          wr_en_nxt_s   = 1'b1;
          addr_nxt_s    = BASE_A;
          data_nxt_s    = in_map[DATA_WIDTH-1:0];
          busy_nxt_s    = 1'b1;
        end else begin
          wr_en_nxt_s   = 1'b0;
          busy_nxt_s    = 1'b0;
        end
      end
      WRITE: begin
        if (beat_s) begin
          idx_nxt_s = idx_inc_s;
          if (last_s) begin
            wr_en_nxt_s = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            wr_en_nxt_s = 1'b1;
            addr_nxt_s  = BASE_A + ADDR_WIDTH'(idx_inc_s);
            data_nxt_s  = shadow_r[sel_s +: DATA_WIDTH];
          end
        end else begin
          // Memory stalled: present the same beat again
          wr_en_nxt_s = wr_en_r;
        end
      end
      DONE: begin
        idx_nxt_s   = IDX_ZERO;
        wr_en_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        idx_nxt_s   = IDX_ZERO;
        wr_en_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Datapath registers: index, shadow map and interface outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r     <= IDX_ZERO;
      shadow_r  <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      idx_r     <= idx_nxt_s;
      if (load_shadow_s) begin
        shadow_r <= in_map;
      end else begin
        shadow_r <= shadow_r;
      end
      wr_en_r   <= wr_en_nxt_s;
      wr_addr_r <= addr_nxt_s;
      wr_data_r <= data_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_map_writer.sv
// Bench for map_writer: two instances (base address 0 and 16) share one
// stimulus stream; a reference queue of expected beats and done pulses is
// filled when a job is issued and drained by a negedge monitor.
module tb_map_writer;

  localparam int N     = 9;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BASE1 = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N*DW-1:0] in_map;
  logic            wr_ready;

  logic            wr_en0, busy0, done0;
  logic [AW-1:0]   wr_addr0;
  logic [DW-1:0]   wr_data0;
  logic            wr_en1, busy1, done1;
  logic [AW-1:0]   wr_addr1;
  logic [DW-1:0]   wr_data1;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int ready_ph = 0;

  typedef struct {
    bit          is_done;
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  map_writer #(.map_width(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_map(in_map),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ready(wr_ready),
    .busy(busy0), .done(done0)
  );

  map_writer #(.map_width(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_map(in_map),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(wr_ready),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-side ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    ready_ph = ready_ph + 1;
    case (ready_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = (ready_ph % 3 == 0);
      default: wr_ready = $urandom_range(0, 1);
    endcase
  end

  // Monitor: compare every cycle against the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_wr_en", {31'd0, wr_en0}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_addr0", {24'd0, wr_addr0}, 32'd0);
      chk("rst_addr1", {24'd0, wr_addr1}, 32'd0);
      chk("rst_data", wr_data0, 32'd0);
    end else begin
      bit exp_beat, exp_done, exp_busy;
      exp_busy = (exp_q.size() > 0);
      exp_beat = exp_busy && !exp_q[0].is_done;
      exp_done = exp_busy && exp_q[0].is_done;
      chk("wr_en0", {31'd0, wr_en0}, {31'd0, exp_beat});
      chk("wr_en1", {31'd0, wr_en1}, {31'd0, exp_beat});
      chk("busy0", {31'd0, busy0}, {31'd0, exp_busy});
      chk("busy1", {31'd0, busy1}, {31'd0, exp_busy});
      chk("done0", {31'd0, done0}, {31'd0, exp_done});
      chk("done1", {31'd0, done1}, {31'd0, exp_done});
      if (exp_beat && wr_en0) begin
        chk("addr0", {24'd0, wr_addr0}, exp_q[0].idx);
        chk("addr1", {24'd0, wr_addr1}, exp_q[0].idx + BASE1);
        chk("data0", wr_data0, exp_q[0].data);
        chk("data1", wr_data1, exp_q[0].data);
        if (wr_ready) void'(exp_q.pop_front());
      end else if (exp_done && done0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [N*DW-1:0] rand_map();
    logic [N*DW-1:0] m;
    for (int i = 0; i < N; i++) m[i*DW +: DW] = $urandom;
    return m;
  endfunction

  // Pulse start for one cycle; the job is expected only if nothing is in flight
  task automatic drive_start(input logic [N*DW-1:0] map);
    bit accepted;
    in_map = map;
    start = 1'b1;
    accepted = (exp_q.size() == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_map = rand_map();
    if (accepted) begin
      for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, i, map[i*DW +: DW]});
      exp_q.push_back('{1'b1, 0, 32'd0});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d entries left after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [N*DW-1:0] m;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] m;
    reset = 1'b0;
    start = 1'b0;
    in_map = '0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Elements -4..4, always ready
    for (int i = 0; i < N; i++) m[i*DW +: DW] = i - 4;
    ready_mode = 0;
    drive_start(m);
    wait_idle(100);
    repeat (2) @(posedge clk);
    #1;

    // Stalls 1,0,0 pattern
    ready_mode = 1;
    drive_start(m);
    wait_idle(200);

    // Second start mid-job ignored, input bus scrambled after capture
    ready_mode = 0;
    drive_start(rand_map());
    repeat (3) @(posedge clk);
    #1;
    drive_start(rand_map());
    wait_idle(100);

    // Reset during beat 5 aborts, fresh job restarts from element 0
    drive_start(rand_map());
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive_start(rand_map());
    wait_idle(100);

    // Sign bit kept: element 0 = 8000_0000
    m = rand_map();
    m[DW-1:0] = 32'h8000_0000;
    drive_start(m);
    wait_idle(100);

    // Start during the done cycle is ignored; start right after is accepted
    drive_start(rand_map());
    while (exp_q.size() > 1) begin
      @(posedge clk);
      #1;
    end
    drive_start(rand_map());
    wait_idle(20);
    drive_start(rand_map());
    wait_idle(100);

    // Back-to-back and random jobs with random memory stalls
    ready_mode = 2;
    for (int j = 0; j < 8; j++) begin
      drive_start(rand_map());
      wait_idle(400);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
